// File: rtl/uart_prog_loader_pkg.sv
// Shared command bytes, reply bytes, error codes and FSM encoding for the UART program loader.
package uart_prog_loader_pkg;
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CMD     = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_NOPROG  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RESP, S_RUN
  } state_t;
endpackage

// File: rtl/byte_word_packer.sv
// Shifts bytes in LSB-first and pulses word_done the cycle after the last byte of a word.
module byte_word_packer import uart_prog_loader_pkg::*; #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               in_vld,
  input  logic [DATA_W-1:0]  in_byte,
  output logic [INSTR_W-1:0] word,
  output logic               word_done
);
  localparam int BPW = INSTR_W / DATA_W;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0] idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word      <= '0;
      idx       <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (clr) begin
        idx <= '0;
      end else if (in_vld) begin
        // newest byte enters at the top so the first byte ends up in the LSBs
        word <= (word >> DATA_W) | (INSTR_W'(in_byte) << (INSTR_W - DATA_W));
        if (idx == IW'(BPW - 1)) begin
          idx       <= '0;
          word_done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/uart_prog_loader.sv
// Frame parser and run controller: loads checksummed programs into imem and gates cpu_run.
module uart_prog_loader import uart_prog_loader_pkg::*; #(
  parameter int DATA_W      = 8,
  parameter int INSTR_W     = 32,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               rx_empty,
  output logic               rx_rd,
  input  logic               tx_full,
  output logic               tx_wr,
  output logic [DATA_W-1:0]  tx_data,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_run,
  output logic               prog_valid,
  output logic [ADDR_W:0]    prog_len,
  output logic [2:0]         err_code
);
  localparam int BPW = INSTR_W / DATA_W;
  localparam int BCW = ADDR_W + 1 + $clog2(BPW);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int LW  = 2 * DATA_W;

  state_t            state, nxt;
  logic [DATA_W-1:0] len_lo, xor_acc;
  logic [ADDR_W:0]   len;
  logic [BCW-1:0]    bytes_left;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] addr;
  logic [LW-1:0]     len_full;
  logic              pop, in_frame, timeout, pk_clr, word_done;

  assign pop      = reset & (state != S_RESP) & !rx_empty;
  assign rx_rd    = pop;
  assign tx_wr    = reset & (state == S_RESP) & !tx_full;
  assign len_full = {rx_data, len_lo};
  assign in_frame = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
  // a byte arriving on the expiry cycle keeps the frame alive
  assign timeout  = in_frame & !pop & (tcnt == TW'(TIMEOUT_CYC - 1));
  assign pk_clr   = timeout | ((state == S_LEN_HI) & pop);
  assign imem_we  = word_done;
  assign imem_addr = addr;

  byte_word_packer #(.DATA_W(DATA_W), .INSTR_W(INSTR_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr),
    .in_vld    (pop & (state == S_DATA)),
    .in_byte   (rx_data),
    .word      (imem_wdata),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      nxt        <= S_IDLE;
      tx_data    <= '0;
      cpu_run    <= 1'b0;
      prog_valid <= 1'b0;
      prog_len   <= '0;
      err_code   <= ERR_NONE;
      len_lo     <= '0;
      len        <= '0;
      bytes_left <= '0;
      tcnt       <= '0;
      addr       <= '0;
      xor_acc    <= '0;
    end else begin
      if (word_done) addr <= addr + 1'b1;
      if (in_frame) tcnt <= pop ? '0 : tcnt + 1'b1;
      else          tcnt <= '0;

      if (timeout) begin
        err_code <= ERR_TIMEOUT;
        tx_data  <= DATA_W'(NAK_BYTE);
        nxt      <= S_IDLE;
        state    <= S_RESP;
      end else begin
        case (state)
          S_IDLE: if (pop) begin
            if (rx_data == DATA_W'(CMD_LOAD)) begin
              state <= S_LEN_LO;
            end else begin
              state <= S_RESP;
              nxt   <= S_IDLE;
              if (rx_data == DATA_W'(CMD_RUN) && prog_valid) begin
                tx_data <= DATA_W'(ACK_BYTE);
                nxt     <= S_RUN;
              end else begin
                tx_data  <= DATA_W'(NAK_BYTE);
                err_code <= (rx_data == DATA_W'(CMD_RUN)) ? ERR_NOPROG : ERR_CMD;
              end
            end
          end
          S_LEN_LO: if (pop) begin
            len_lo <= rx_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: if (pop) begin
            if (len_full == '0 || {1'b0, len_full} > (LW + 1)'(2 ** ADDR_W)) begin
              err_code <= ERR_LEN;
              tx_data  <= DATA_W'(NAK_BYTE);
              nxt      <= S_IDLE;
              state    <= S_RESP;
            end else begin
              len        <= len_full[ADDR_W:0];
              bytes_left <= BCW'(len_full[ADDR_W:0]) * BCW'(BPW);
              prog_valid <= 1'b0;
              cpu_run    <= 1'b0;
              addr       <= '0;
              xor_acc    <= '0;
              state      <= S_DATA;
            end
          end
          S_DATA: if (pop) begin
            xor_acc    <= xor_acc ^ rx_data;
            bytes_left <= bytes_left - 1'b1;
            if (bytes_left == BCW'(1)) state <= S_CSUM;
          end
          S_CSUM: if (pop) begin
            nxt   <= S_IDLE;
            state <= S_RESP;
            if (rx_data == xor_acc) begin
              prog_valid <= 1'b1;
              prog_len   <= len;
              err_code   <= ERR_NONE;
              tx_data    <= DATA_W'(ACK_BYTE);
            end else begin
              err_code <= ERR_CSUM;
              tx_data  <= DATA_W'(NAK_BYTE);
            end
          end
          S_RESP: if (!tx_full) begin
            state <= nxt;
            if (nxt == S_RUN) cpu_run <= 1'b1;
          end
          S_RUN: if (pop && rx_data == DATA_W'(CMD_HALT)) begin
            cpu_run <= 1'b0;
            tx_data <= DATA_W'(ACK_BYTE);
            nxt     <= S_IDLE;
            state   <= S_RESP;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized scoreboard bench: a byte-level frame model predicts replies, imem writes and status.
module tb_uart_prog_loader;
  import uart_prog_loader_pkg::*;
  localparam int DATA_W = 8, INSTR_W = 32, ADDR_W = 8, TO = 50, BPW = INSTR_W / DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0]  a;
    logic [INSTR_W-1:0] d;
  } wr_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [DATA_W-1:0] rx_data = '0;
  logic rx_empty = 1'b1, tx_full = 1'b0;
  logic rx_rd, tx_wr, imem_we, cpu_run, prog_valid;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [ADDR_W:0] prog_len;
  logic [2:0] err_code;

  logic [7:0] rx_q[$], exp_tx[$], pl[$];
  wr_t exp_wr[$];
  int checks = 0, fails = 0, cyc = 0, last_pop = 0, last_tx = 0, tx_cnt = 0;
  bit m_pv = 0, m_run = 0;
  logic [ADDR_W:0] m_len = '0;
  logic [2:0] m_err = '0;

  uart_prog_loader #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
    .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .prog_valid(prog_valid), .prog_len(prog_len), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RX FIFO model: head presented on the falling edge, popped when the DUT commits to reading it
  always @(negedge clk) begin
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
    #1;
    if (rx_rd) begin
      chk("rx_rd_nonempty", 64'(rx_q.size() != 0), 1);
      if (rx_q.size() != 0) begin
        void'(rx_q.pop_front());
        last_pop = cyc;
      end
    end
  end

  // monitor: pops scoreboard entries whenever the DUT emits a reply or an imem write
  always @(negedge clk) begin
    wr_t w;
    #2;
    if (tx_wr) begin
      tx_cnt++;
      last_tx = cyc;
      chk("tx_wr_while_full", tx_full, 0);
      chk("tx_expected", 64'(exp_tx.size() != 0), 1);
      if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
    end
    if (imem_we) begin
      chk("imem_expected", 64'(exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        chk("imem_addr", imem_addr, w.a);
        chk("imem_wdata", imem_wdata, w.d);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic settle(input string name);
    int n = 0;
    while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_wr.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_drain"}, 64'(n < 3000), 1);
    chk({name, "_prog_valid"}, prog_valid, m_pv);
    chk({name, "_prog_len"}, prog_len, m_len);
    chk({name, "_err_code"}, err_code, m_err);
    chk({name, "_cpu_run"}, cpu_run, m_run);
  endtask

  task automatic fill_rand(input int nbytes);
    pl.delete();
    for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom));
  endtask

  // sends a load frame from pl[] and predicts the result; force_cs overrides the checksum byte
  task automatic load(input int len, input bit force_cs, input logic [7:0] cs);
    logic [7:0] x = '0;
    logic [7:0] sent;
    wr_t e;
    send(CMD_LOAD); send(8'(len)); send(8'(len >> 8));
    if (len == 0 || len > 2 ** ADDR_W) begin
      exp_tx.push_back(NAK_BYTE);
      m_err = ERR_LEN;
      return;
    end
    m_pv = 0;
    m_run = 0;
    for (int i = 0; i < len; i++) begin
      e.a = ADDR_W'(i);
      e.d = '0;
      for (int b = 0; b < BPW; b++) begin
        e.d = e.d | (INSTR_W'(pl[i * BPW + b]) << (8 * b));
        x = x ^ pl[i * BPW + b];
        send(pl[i * BPW + b]);
      end
      exp_wr.push_back(e);
    end
    sent = force_cs ? cs : x;
    send(sent);
    if (sent == x) begin
      exp_tx.push_back(ACK_BYTE);
      m_pv = 1; m_len = ADDR_W'(len) + '0; m_len = (ADDR_W + 1)'(len); m_err = ERR_NONE;
    end else begin
      exp_tx.push_back(NAK_BYTE);
      m_err = ERR_CSUM;
    end
  endtask

  task automatic run_cmd();
    send(CMD_RUN);
    if (m_pv) begin exp_tx.push_back(ACK_BYTE); m_run = 1; end
    else begin exp_tx.push_back(NAK_BYTE); m_err = ERR_NOPROG; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d;
    logic [7:0] b;
    #2 reset = 1'b0;
    #2;
    chk("rst_rx_rd", rx_rd, 0);       chk("rst_tx_wr", tx_wr, 0);
    chk("rst_tx_data", tx_data, 0);   chk("rst_imem_we", imem_we, 0);
    chk("rst_cpu_run", cpu_run, 0);   chk("rst_prog_valid", prog_valid, 0);
    chk("rst_err", err_code, 0);      chk("rst_prog_len", prog_len, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd();                         settle("run_noprog");
    pl = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    load(2, 0, 8'h00);                 settle("load_known");
    load(2, 1, 8'h00);                 settle("load_badcs");
    load(2, 0, 8'h00);                 settle("reload_known");

    for (int i = 0; i < 4; i++) begin
      do b = 8'($urandom); while (b == CMD_LOAD || b == CMD_RUN);
      send(b); exp_tx.push_back(NAK_BYTE); m_err = ERR_CMD;
      settle("bad_cmd");
    end

    load(0, 0, 8'h00);                 settle("len_zero");
    load(257, 0, 8'h00);               settle("len_257");
    load(16'hFFFF, 0, 8'h00);          settle("len_ffff");

    for (int i = 0; i < 6; i++) begin
      int len;
      len = $urandom_range(1, 6);
      fill_rand(len * BPW);
      load(len, ($urandom_range(0, 2) == 0), 8'($urandom));
      settle("rand_load");
    end

    fill_rand(256 * BPW);
    load(256, 0, 8'h00);               settle("max_load");

    run_cmd();                         settle("run_ack");
    for (int i = 0; i < 6; i++) begin
      do b = 8'($urandom); while (b == CMD_HALT);
      if (i == 0) b = CMD_LOAD;
      if (i == 1) b = 8'h5A;
      send(b);
    end
    settle("run_discard");
    send(CMD_HALT); exp_tx.push_back(ACK_BYTE); m_run = 0;
    settle("halt");

    // stall the reply behind a full TX FIFO
    tx_full = 1'b1;
    t0 = tx_cnt;
    run_cmd();
    repeat (20) @(negedge clk);
    chk("txfull_no_write", tx_cnt - t0, 0);
    tx_full = 1'b0;
    settle("txfull_release");
    chk("txfull_one_pulse", tx_cnt - t0, 1);
    send(CMD_HALT); exp_tx.push_back(ACK_BYTE); m_run = 0;
    settle("halt2");

    // timeout with a partial word pending
    fill_rand(2);
    send(CMD_LOAD); send(8'h01); send(8'h00); send(pl[0]); send(pl[1]);
    exp_tx.push_back(NAK_BYTE); m_err = ERR_TIMEOUT; m_pv = 0;
    settle("timeout");
    d = last_tx - last_pop;
    chk("timeout_latency_lo", 64'(d >= TO), 1);
    chk("timeout_latency_hi", 64'(d <= TO + 2), 1);

    // reset in the middle of DATA after one complete word
    fill_rand(2 * BPW);
    send(CMD_LOAD); send(8'h02); send(8'h00);
    for (int i = 0; i < BPW + 1; i++) send(pl[i]);
    exp_wr.push_back('{a: '0, d: {pl[3], pl[2], pl[1], pl[0]}});
    repeat (15) @(negedge clk);
    chk("pre_reset_addr", imem_addr, 1);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_rx_rd", rx_rd, 0);          chk("mid_rst_tx_wr", tx_wr, 0);
    chk("mid_rst_imem_addr", imem_addr, 0);  chk("mid_rst_imem_wdata", imem_wdata, 0);
    chk("mid_rst_imem_we", imem_we, 0);      chk("mid_rst_prog_valid", prog_valid, 0);
    chk("mid_rst_err", err_code, 0);         chk("mid_rst_prog_len", prog_len, 0);
    rx_q.delete(); exp_tx.delete(); exp_wr.delete();
    m_pv = 0; m_run = 0; m_len = '0; m_err = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fill_rand(3 * BPW);
    load(3, 0, 8'h00);                 settle("post_reset_load");
    run_cmd();                         settle("post_reset_run");
    send(CMD_HALT); exp_tx.push_back(ACK_BYTE); m_run = 0;
    settle("post_reset_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
